alu_share_arb: RTL
==================

// Module: alu_share_arb
// PURPOSE
//  Shares one combinational 32-bit ALU (4-bit op code, 32-bit result, 1-bit compare flag) between two requesters.
//  Example pair: the execute stage and an address/branch unit.
//  Arbitrates with valid/ready, registers the operands and captures result+flag.
//  Returns the response to the granted requester with its own valid/ready.
// PARAMETERS
//  DATA_W  32  operand/result width
//  OP_W    4   ALU op-code width (ops 0..9 give a result; 10..15 give the compare flag)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous, active-high reset
//  req_valid_i[k] in   1       k=0,1: request valid
//  req_ready_o[k] out  1       request accepted when valid&&ready
//  req_op_i[k]    in   OP_W    ALU op code
//  req_a_i[k]     in   DATA_W  operand A
//  req_b_i[k]     in   DATA_W  operand B
//  resp_valid_o[k] out 1       response valid for requester k
//  resp_ready_i[k] in  1       requester k accepts response
//  resp_res_o     out  DATA_W  captured ALU result (shared bus, qualified by resp_valid_o)
//  resp_flag_o    out  1       captured compare flag
//  alu_op_o       out  OP_W    to ALU: registered op
//  alu_a_o        out  DATA_W  to ALU: registered A
//  alu_b_o        out  DATA_W  to ALU: registered B
//  alu_res_i      in   DATA_W  from ALU: result
//  alu_flag_i     in   1       from ALU: compare flag
// BEHAVIOUR
//  FSM: IDLE -> EXEC -> RESP.
//   IDLE: accept a request on handshake, go to EXEC.
//   EXEC: always one cycle; capture alu_res_i/alu_flag_i, go to RESP.
//   RESP: hold until resp_ready_i[owner]. Then go to EXEC if a new request is accepted in the same cycle, else go to IDLE.
//  Request acceptance:
//   req_ready_o[k] = grant==k && (state==IDLE || (state==RESP && resp handshake this cycle)).
//   Grant is combinational from req_valid_i; ready may depend on valid.
//  Arbitration:
//   If only one requester is valid, it is granted.
//   If both are valid, grant the requester that is not last_grant (round-robin).
//   last_grant updates only on an accepted request.
//  Acceptance cycle N:
//   op/A/B are registered to alu_*_o and owner is latched.
//   Cycle N+1 (EXEC): ALU result is captured.
//   Cycle N+2: resp_valid_o[owner]=1.
//   Minimum latency is 2 cycles; back-to-back throughput is 1 op per 2 cycles.
//  resp_valid_o[k]:
//   At most one bit is set, only for the owner.
//   Once set, it stays asserted with stable res/flag until its handshake; no drop, no change.
//  Flag: resp_flag_o is flag_i as captured; resp_res_o is res_i as captured. There is no op-dependent masking.
//  Reset (any cycle, including mid-EXEC/RESP):
//   State goes to IDLE and any in-flight operation is discarded without a response.
//   All outputs go to 0: req_ready_o=0 while rst, alu_*_o=0, resp_*=0.
//   last_grant resets to 1, so requester 0 wins the first contest.
//  Holding valid while not ready: the requester must hold op/A/B stable.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN
//   Defined: fixed priority; requester 0 always wins when both are valid, and last_grant is unused.
//   Undefined (default): round-robin as above.
// STRUCTURE
//  Package alu_arb_pkg holds:
//   op-code localparams ADD=0 SUB=1 SLL=2 SLTS=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 EQ=10 NE=11 LTS=12 GES=13 LTU=14 GEU=15;
//   state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
//   DATA_W/OP_W defaults.
//  Sub-module arb2_rr: 2-way grant logic plus last_grant register (macro-selectable priority).
//  Top holds the FSM, operand/response registers and response routing.
// TESTING
//  Single op: r0 valid, ADD A=5 B=7; ALU model responds.
//   Expected: ready at N, resp_valid_o[0] at N+2, res=12, flag=0.
//  Compare op: r1 SLTU A=1 B=0xFFFFFFFF.
//   Expected: res=1. Then EQ A=B=3: flag=1 and res=0.
//  Contention after reset: both valid (r0 ADD 1,1; r1 SUB 9,4).
//   Round-robin: r0 served first (res 2), then r1 (res 5), alternating after that.
//   With ALU_ARB_FIXED_PRIO_EN: r0 repeats while it stays valid.
//  Backpressure: resp_ready_i[0]=0 for 5 cycles.
//   Expected: resp_valid_o[0] and res held stable, no new accept.
//   On ready, the pending r1 request is accepted in the same cycle.
//  Reset mid-op: assert rst during EXEC.
//   Expected: next cycle all outputs 0, no response, state IDLE; the next request is served normally.
//  Random: 10k random ops, valids and readies vs reference model.
//   Checks: ordering per requester, no lost/duplicated responses, one-hot resp_valid.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Holds the default widths, the ALU op-code map and the arbiter FSM state
// encoding. Ops 0..9 produce a result word; ops 10..15 produce only the
// compare flag.
package alu_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_OP_W   = 4;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] SLL  = 4'd2;
    localparam logic [3:0] SLTS = 4'd3;
    localparam logic [3:0] SLTU = 4'd4;
    localparam logic [3:0] XOR  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SRA  = 4'd7;
    localparam logic [3:0] OR   = 4'd8;
    localparam logic [3:0] AND  = 4'd9;
    localparam logic [3:0] EQ   = 4'd10;
    localparam logic [3:0] NE   = 4'd11;
    localparam logic [3:0] LTS  = 4'd12;
    localparam logic [3:0] GES  = 4'd13;
    localparam logic [3:0] LTU  = 4'd14;
    localparam logic [3:0] GEU  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_arb2_rr.sv
// arb2_rr: two-way grant logic for the shared ALU.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   valid[1:0]- request valids
//   accept    - the granted request was taken this cycle
//   grant     - index of the requester that would be taken this cycle
// Macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins
// contests); otherwise contests alternate using a last_grant register.
module arb2_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // No history is kept; the clock, reset and accept are not needed.
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, accept};

    assign grant = valid[1] && !valid[0];
`else
    logic last_grant;

    always_comb begin
        grant = valid[1];
        if (valid[0] && valid[1])
            grant = ~last_grant;
    end

    // Reset to 1 so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between two requesters.
// A request is registered onto alu_*_o when accepted, the ALU output is
// captured one cycle later, and the response is presented to the owning
// requester until it is taken. A new request can be accepted in the same
// cycle as the response handshake.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   req_valid_i/req_ready_o[1:0]     - request handshake per requester
//   req_op_i/req_a_i/req_b_i[1:0]    - request op code and operands
//   resp_valid_o/resp_ready_i[1:0]   - response handshake per requester
//   resp_res_o, resp_flag_o          - captured ALU result and flag
//   alu_op_o, alu_a_o, alu_b_o       - registered operands to the ALU
//   alu_res_i, alu_flag_i            - ALU result and compare flag
// Configuration: ALU_ARB_FIXED_PRIO_EN (see arb2_rr).
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0][OP_W-1:0]   req_op_i,
    input  logic [1:0][DATA_W-1:0] req_a_i,
    input  logic [1:0][DATA_W-1:0] req_b_i,
    output logic [1:0]             resp_valid_o,
    input  logic [1:0]             resp_ready_i,
    output logic [DATA_W-1:0]      resp_res_o,
    output logic                   resp_flag_o,
    output logic [OP_W-1:0]        alu_op_o,
    output logic [DATA_W-1:0]      alu_a_o,
    output logic [DATA_W-1:0]      alu_b_o,
    input  logic [DATA_W-1:0]      alu_res_i,
    input  logic                   alu_flag_i
);

    state_t state, state_nxt;
    logic   owner;
    logic   grant;
    logic   resp_hs;
    logic   slot;
    logic   accept;

    // A request slot opens when idle or when the pending response is
    // being taken this cycle; never while reset is asserted.
    assign resp_hs = (state == RESP) && resp_ready_i[owner];
    assign slot    = !rst && ((state == IDLE) || resp_hs);
    assign accept  = slot && req_valid_i[grant];

    arb2_rr u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (req_valid_i),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        req_ready_o = '0;
        if (slot)
            req_ready_o[grant] = 1'b1;
    end

    always_comb begin
        resp_valid_o = '0;
        if (state == RESP)
            resp_valid_o[owner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_hs) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= 1'b0;
            alu_op_o    <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            resp_res_o  <= '0;
            resp_flag_o <= 1'b0;
        end else begin
            if (accept) begin
                owner    <= grant;
                alu_op_o <= req_op_i[grant];
                alu_a_o  <= req_a_i[grant];
                alu_b_o  <= req_b_i[grant];
            end
            // Response registers only load in EXEC, so they stay frozen
            // for the whole RESP hold.
            if (state == EXEC) begin
                resp_res_o  <= alu_res_i;
                resp_flag_o <= alu_flag_i;
            end
        end
    end

endmodule
